// File: rtl/ysyx_22050550_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller.
// Holds the 2-bit FSM state encoding, the reset PC and the address/instruction widths.
// Optional build macro: YSYX_22050550_FETCH_MISALIGN_EN (misaligned-PC detection in the top).
package ysyx_22050550_fetch_ctrl_pkg;

  localparam int          XLEN_DEF     = 64;
  localparam int          INST_W       = 32;
  localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/ysyx_22050550_redir_arb.sv
// Fixed-priority redirect select: trap > mret > branch/jump redirect.
// Purely combinational: zero latency.
// No backpressure: any valid redirect is accepted in the same cycle.
module ysyx_22050550_redir_arb
  import ysyx_22050550_fetch_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            mret_valid,
  input  logic [XLEN-1:0] mret_pc,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_pc,
  output logic            accept,
  output logic [XLEN-1:0] target
);

  // Highest-priority source overrides the lower ones; target is don't-care when accept=0.
  always_comb begin
    accept = trap_valid | mret_valid | redir_valid;
    target = redir_pc;
    if (mret_valid) target = mret_pc;
    if (trap_valid) target = trap_pc;
  end

endmodule

// File: rtl/ysyx_22050550_fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, single-entry IF/ID buffer.
// Latency: request->response->handoff, one instruction per 3 cycles at best (REQ, WAIT, HOLD).
// Backpressure: if_ready=0 holds the buffer stable and stalls new requests; redirects flush.
// Optional build macro: YSYX_22050550_FETCH_MISALIGN_EN adds output fetch_misalign and
// suppresses requests for PCs with non-zero low two bits.
module ysyx_22050550_fetch_ctrl
  import ysyx_22050550_fetch_ctrl_pkg::*;
#(
  parameter int             XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF[XLEN-1:0]
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              redir_valid,
  input  logic [XLEN-1:0]   redir_pc,
  input  logic              trap_valid,
  input  logic [XLEN-1:0]   trap_pc,
  input  logic              mret_valid,
  input  logic [XLEN-1:0]   mret_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [XLEN-1:0]   if_pc,
  output logic [INST_W-1:0] if_inst,
  output logic              flush
`ifdef YSYX_22050550_FETCH_MISALIGN_EN
 ,output logic              fetch_misalign
`endif
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   w_pc_nxt;
  logic              r_stale;
  logic              w_stale_nxt;
  logic [XLEN-1:0]   r_if_pc;
  logic [INST_W-1:0] r_if_inst;
  logic              w_capture;
  logic              w_arb_accept;
  logic [XLEN-1:0]   w_arb_target;
  logic              w_accept;
  logic              w_pc_ok;
  logic              w_req_fire;

  ysyx_22050550_redir_arb #(
    .XLEN (XLEN)
  ) u_redir_arb (
    .trap_valid  (trap_valid),
    .trap_pc     (trap_pc),
    .mret_valid  (mret_valid),
    .mret_pc     (mret_pc),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .accept      (w_arb_accept),
    .target      (w_arb_target)
  );

  // Redirects are ignored while reset is held.
  assign w_accept = w_arb_accept & ~reset;

`ifdef YSYX_22050550_FETCH_MISALIGN_EN
  assign w_pc_ok = (r_pc[1:0] == 2'b00);
`else
  assign w_pc_ok = 1'b1;
`endif

  assign w_req_fire = imem_req_valid & imem_req_ready;

  // Next state, next pc/stale flag and the combinational outputs.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_stale_nxt    = r_stale;
    w_capture      = 1'b0;
    imem_req_valid = (r_state == S_REQ) & w_pc_ok & ~reset;
    imem_req_addr  = r_pc;
    if_valid       = (r_state == S_HOLD) & ~reset;
    if_pc          = r_if_pc;
    if_inst        = r_if_inst;
    flush          = w_accept;
`ifdef YSYX_22050550_FETCH_MISALIGN_EN
    fetch_misalign = (r_state == S_REQ) & ~w_pc_ok & ~reset;
`endif
    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        // A redirect racing the handshake makes the in-flight response stale.
        if (w_req_fire) begin
          w_state_nxt = S_WAIT;
          w_stale_nxt = w_accept;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          w_state_nxt = S_REQ;
          w_stale_nxt = 1'b0;
          if (!r_stale && !w_accept) begin
            w_capture   = 1'b1;
            w_pc_nxt    = r_pc + XLEN'(4);
            w_state_nxt = S_HOLD;
          end
        end else if (w_accept) begin
          w_stale_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        // A redirect drops the buffer even if ID takes it this cycle.
        if (w_accept || if_ready) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_accept) w_pc_nxt = w_arb_target;
  end

  // FSM state, fetch pointer and stale flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_stale <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_stale <= w_stale_nxt;
    end
  end

  // IF/ID output buffer, loaded only by a non-stale response.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_if_pc   <= '0;
      r_if_inst <= '0;
    end else if (w_capture) begin
      r_if_pc   <= r_pc;
      r_if_inst <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_ysyx_22050550_fetch_ctrl.sv
// Self-checking bench for ysyx_22050550_fetch_ctrl: directed scenarios then randomized traffic.
// The reference model tracks the architectural next-fetch PC and a latency-randomized memory.
// Optional build macro: YSYX_22050550_FETCH_MISALIGN_EN enables the misaligned-PC scenario.
module tb_ysyx_22050550_fetch_ctrl;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        redir_valid, trap_valid, mret_valid;
  logic [63:0] redir_pc, trap_pc, mret_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid, if_ready;
  logic [63:0] if_pc;
  logic [31:0] if_inst;
  logic        flush;
`ifdef YSYX_22050550_FETCH_MISALIGN_EN
  logic        fetch_misalign;
`endif

  always #5 clock = ~clock;

  ysyx_22050550_fetch_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .redir_valid    (redir_valid),
    .redir_pc       (redir_pc),
    .trap_valid     (trap_valid),
    .trap_pc        (trap_pc),
    .mret_valid     (mret_valid),
    .mret_pc        (mret_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .flush          (flush)
`ifdef YSYX_22050550_FETCH_MISALIGN_EN
   ,.fetch_misalign (fetch_misalign)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Stimulus for the next cycle
  logic        s_reset, s_req_rdy, s_if_rdy, s_trap, s_mret, s_redir;
  logic [63:0] s_trap_pc, s_mret_pc, s_redir_pc;
  int          s_lat;

  // Reference model state
  logic [63:0] exp_next;
  bit          mem_pend;
  int          mem_cd;
  logic [63:0] mem_addr;
  bit          p_stall;
  logic [63:0] p_if_pc;
  logic [31:0] p_if_inst;
  int          idle_cnt;

  // Observations of the last cycle
  bit          o_hs, o_flush, o_deliver, o_ifv;
  logic [63:0] o_hs_addr;
  int          cyc = 0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  task automatic quiet_stim();
    s_reset = 1'b0; s_req_rdy = 1'b1; s_if_rdy = 1'b1; s_lat = 1;
    s_trap = 1'b0; s_mret = 1'b0; s_redir = 1'b0;
    s_trap_pc = '0; s_mret_pc = '0; s_redir_pc = '0;
  endtask

  // One clock cycle: drive at negedge, sample 1ns later, check and advance the model.
  task automatic step();
    logic        any;
    logic [63:0] tgt;
    @(negedge clock);
    reset = s_reset; imem_req_ready = s_req_rdy; if_ready = s_if_rdy;
    trap_valid = s_trap; mret_valid = s_mret; redir_valid = s_redir;
    trap_pc = s_trap_pc; mret_pc = s_mret_pc; redir_pc = s_redir_pc;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    if (s_reset) mem_pend = 0;
    else if (mem_pend) begin
      mem_cd--;
      if (mem_cd == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mem_addr);
        mem_pend = 0;
      end
    end
    #1;
    cyc++;
    any = s_trap | s_mret | s_redir;
    tgt = s_trap ? s_trap_pc : (s_mret ? s_mret_pc : s_redir_pc);
    o_hs = imem_req_valid && imem_req_ready;
    o_hs_addr = imem_req_addr;
    o_flush = flush;
    o_ifv = if_valid;
    o_deliver = 0;
    if (s_reset) begin
      exp_next = RESET_PC; p_stall = 0; idle_cnt = 0;
    end else begin
      chk("flush", flush, any);
      if (p_stall) begin
        chk("hold_vld", if_valid, 1'b1);
        chk("hold_pc", if_pc, p_if_pc);
        chk("hold_inst", if_inst, p_if_inst);
      end
      if (o_hs) begin
        chk("req_addr", imem_req_addr, exp_next);
        chk("one_outstanding", mem_pend, 0);
        mem_pend = 1; mem_cd = s_lat; mem_addr = imem_req_addr;
      end
      if (if_valid && if_ready && !any) begin
        chk("if_pc", if_pc, exp_next);
        chk("if_inst", if_inst, mem_word(exp_next));
        exp_next = exp_next + 64'd4;
        o_deliver = 1;
      end
      if (any) exp_next = tgt;
      p_stall = if_valid && !if_ready && !any;
      p_if_pc = if_pc; p_if_inst = if_inst;
      idle_cnt = (o_deliver || any) ? 0 : idle_cnt + 1;
      if (idle_cnt > 200) begin
        chk("watchdog", idle_cnt, 0);
        idle_cnt = 0;
      end
    end
  endtask

  task automatic wait_hs(input string tag, output logic [63:0] addr);
    int k = 0;
    do begin step(); k++; end while (!o_hs && k < 40);
    chk({tag, "_seen"}, o_hs, 1);
    addr = o_hs_addr;
  endtask

  task automatic wait_ifv(input string tag);
    int k = 0;
    do begin step(); k++; end while (!o_ifv && k < 40);
    chk({tag, "_seen"}, o_ifv, 1);
  endtask

  initial begin
    logic [63:0] a;
    logic [63:0] saved_pc;
    int          nh, nd, last_dv, k;

    reset = 1'b1; imem_req_ready = 1'b0; if_ready = 1'b0;
    trap_valid = 1'b0; mret_valid = 1'b0; redir_valid = 1'b0;
    trap_pc = '0; mret_pc = '0; redir_pc = '0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    mem_pend = 0; mem_cd = 0; mem_addr = '0; exp_next = RESET_PC;
    p_stall = 0; p_if_pc = '0; p_if_inst = '0; idle_cnt = 0;

    quiet_stim();
    s_reset = 1'b1; step(); step();
    s_reset = 1'b0;

    // Reset state (first cycle out of reset is IDLE)
    step();
    chk("rst_req_vld", imem_req_valid, 1'b0);
    chk("rst_if_vld", if_valid, 1'b0);
    chk("rst_flush", flush, 1'b0);
    chk("rst_if_pc", if_pc, 64'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    chk("rst_pc", imem_req_addr, RESET_PC);
`ifdef YSYX_22050550_FETCH_MISALIGN_EN
    chk("rst_misalign", fetch_misalign, 1'b0);
`endif

    // Boot sequence with single-cycle memory: requests every 3 cycles
    nh = 0; nd = 0; last_dv = -1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (o_hs && nh < 3) begin
        chk($sformatf("boot_req%0d", nh), o_hs_addr, RESET_PC + 64'(4 * nh));
        nh++;
      end
      if (o_deliver) begin
        if (last_dv >= 0) chk("boot_gap", 64'(cyc - last_dv), 64'd3);
        last_dv = cyc;
        nd++;
      end
    end
    chk("boot_req_count", 64'(nh), 64'd3);

    // ID stalls for 5 cycles in HOLD
    s_if_rdy = 1'b0;
    wait_ifv("stall");
    saved_pc = if_pc;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_no_req", imem_req_valid, 1'b0);
      chk("stall_pc", if_pc, saved_pc);
    end
    s_if_rdy = 1'b1;
    step();

    // Redirect during WAIT, response two cycles later is dropped
    s_lat = 3;
    wait_hs("w_hs", a);
    s_lat = 1;
    s_redir = 1'b1; s_redir_pc = 64'h8000_0100;
    step();
    chk("w_flush", o_flush, 1'b1);
    s_redir = 1'b0;
    step();
    chk("w_flush_pulse", o_flush, 1'b0);
    wait_hs("w_next", a);
    chk("w_next_addr", a, 64'h8000_0100);

    // All three redirects together: trap wins
    s_trap = 1'b1; s_trap_pc = 64'h8000_1000;
    s_mret = 1'b1; s_mret_pc = 64'h8000_2000;
    s_redir = 1'b1; s_redir_pc = 64'h8000_3000;
    step();
    chk("prio_flush", o_flush, 1'b1);
    s_trap = 1'b0; s_mret = 1'b0; s_redir = 1'b0;
    wait_hs("prio", a);
    chk("prio_addr", a, 64'h8000_1000);

    // Redirect in REQ without handshake: address switches next cycle
    s_req_rdy = 1'b0;
    k = 0;
    do begin step(); k++; end while (!imem_req_valid && k < 40);
    chk("abort_req_seen", imem_req_valid, 1'b1);
    s_redir = 1'b1; s_redir_pc = 64'h8000_5000;
    step();
    s_redir = 1'b0;
    step();
    chk("abort_addr", imem_req_addr, 64'h8000_5000);
    chk("abort_vld", imem_req_valid, 1'b1);

    // Redirect in the same cycle as the handshake
    s_req_rdy = 1'b1; s_redir = 1'b1; s_redir_pc = 64'h8000_4000;
    step();
    chk("hsr_hs", o_hs, 1'b1);
    chk("hsr_flush", o_flush, 1'b1);
    s_redir = 1'b0;
    wait_hs("hsr", a);
    chk("hsr_addr", a, 64'h8000_4000);

`ifdef YSYX_22050550_FETCH_MISALIGN_EN
    // Misaligned target: no request until an aligned redirect
    s_redir = 1'b1; s_redir_pc = 64'h8000_0102;
    step();
    s_redir = 1'b0;
    k = 0;
    do begin step(); k++; end while (!fetch_misalign && k < 40);
    chk("mis_seen", fetch_misalign, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mis_hold", fetch_misalign, 1'b1);
      chk("mis_no_req", imem_req_valid, 1'b0);
    end
    s_redir = 1'b1; s_redir_pc = 64'h8000_0200;
    step();
    s_redir = 1'b0;
    wait_hs("mis_fix", a);
    chk("mis_fix_addr", a, 64'h8000_0200);
    chk("mis_clear", fetch_misalign, 1'b0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      s_reset    = ($urandom_range(0, 999) == 0);
      s_req_rdy  = ($urandom_range(0, 3) != 0);
      s_if_rdy   = ($urandom_range(0, 2) != 0);
      s_lat      = $urandom_range(1, 3);
      s_trap     = ($urandom_range(0, 29) == 0);
      s_mret     = ($urandom_range(0, 29) == 0);
      s_redir    = ($urandom_range(0, 9) == 0);
      s_trap_pc  = 64'h8000_0000 + {50'd0, 12'($urandom_range(0, 4095)), 2'b00};
      s_mret_pc  = 64'h8000_0000 + {50'd0, 12'($urandom_range(0, 4095)), 2'b00};
      s_redir_pc = 64'h8000_0000 + {50'd0, 12'($urandom_range(0, 4095)), 2'b00};
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22050550_fetch_ctrl.md
YSYX_22050550_FETCH_CTRL -- requirements
Module: ysyx_22050550_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 64'h80000000: first fetch address after reset.
REQ-002 Parameter XLEN, default 64: PC and address width.
REQ-003 Signal clock, input, 1 bit: sole clock; reset, synchronous, active-high.
REQ-004 Signal reset, input, 1 bit: synchronous, active-high.
REQ-005 Signals redir_valid (input, 1) and redir_pc (input, XLEN): ID-stage jump/branch redirect.
REQ-006 Signals trap_valid (input, 1) and trap_pc (input, XLEN): ecall/interrupt vector redirect.
REQ-007 Signals mret_valid (input, 1) and mret_pc (input, XLEN): mret return redirect.
REQ-008 Signals imem_req_valid (output, 1), imem_req_ready (input, 1) and imem_req_addr (output, XLEN): instruction-memory request channel.
REQ-009 Signals imem_rsp_valid (input, 1) and imem_rsp_data (input, 32): instruction-memory response; always accepted, never back-pressured.
REQ-010 Signals if_valid (output, 1), if_ready (input, 1), if_pc (output, XLEN) and if_inst (output, 32): IF/ID handoff.
REQ-011 Signal flush, output, 1 bit: high in any cycle in which a redirect is accepted.

Function
REQ-012 The block SHALL have four states: IDLE, REQ, WAIT and HOLD. It SHALL allow at most one outstanding memory request.
REQ-013 IDLE SHALL move to REQ in the next cycle.
REQ-014 In REQ: imem_req_valid=1 and imem_req_addr=pc. A request handshake (valid&&ready) SHALL move the block to WAIT.
REQ-015 In WAIT: imem_rsp_valid SHALL capture {pc, imem_rsp_data} into the output buffer, update pc to pc+4 (modulo 2^XLEN) and move the block to HOLD.
REQ-016 In HOLD: if_valid=1. The handshake if_valid&&if_ready SHALL move the block to REQ. if_pc and if_inst SHALL stay stable while if_valid=1 and if_ready=0.
REQ-017 Redirect priority SHALL be trap > mret > redir. At most one redirect is accepted per cycle. A redirect is accepted in any state outside reset. On acceptance:
- pc <= selected target;
- flush=1 in the same cycle (combinational).
REQ-018 A redirect accepted in HOLD SHALL drop the buffer: if_valid=0 next cycle and next state REQ. This applies even if if_ready=1 in that same cycle; the instruction is still handed off to ID, and ID discards it on flush.
REQ-019 A redirect accepted in WAIT SHALL set a stale flag. The next response is discarded: no capture and no pc increment. The block then moves to REQ.
REQ-020 If the response arrives in the same cycle as the redirect, that response SHALL be discarded and the block SHALL move to REQ.
REQ-021 A redirect accepted in REQ without a request handshake SHALL make imem_req_addr take the new pc in the next cycle; memory treats this as an abort. A redirect in REQ with a handshake in the same cycle SHALL move the block to WAIT with stale set.
REQ-022 Minimum sustained throughput SHALL be one instruction per 3 cycles (REQ, WAIT, HOLD), assuming single-cycle memory and if_ready=1.

Reset
REQ-023 Reset SHALL set: state=IDLE, pc=RESET_PC, stale=0, if_valid=0, imem_req_valid=0, flush=0, if_pc=0, if_inst=0, and fetch_misalign=0 when REQ-025 applies.
REQ-024 Reset asserted mid-request SHALL abandon the outstanding transaction. Memory is reset by the same signal, so no late response arrives.

Configuration
REQ-025 When macro YSYX_22050550_FETCH_MISALIGN_EN is defined, the block SHALL add output fetch_misalign (1 bit). When the REQ-state pc has pc[1:0]!=0:
- no request is issued;
- fetch_misalign is held at 1 until a redirect with an aligned target;
- imem_req_valid=0.
REQ-026 When YSYX_22050550_FETCH_MISALIGN_EN is undefined, the port SHALL be absent and addresses SHALL be issued unchecked.

Structure
REQ-027 The shared define file SHALL hold the state encodings (2 bits), the RESET_PC constant and the XLEN/instruction widths.
REQ-028 Sub-module ysyx_22050550_redir_arb SHALL implement the fixed-priority redirect select (target plus accept). Everything else SHALL be flat.

Verification
REQ-029 Reset, single-cycle memory, if_ready=1 -> requests at 0x80000000, 0x80000004 and 0x80000008, with if_valid every 3rd cycle.
REQ-030 if_ready=0 for 5 cycles in HOLD -> if_pc and if_inst stable; no new request issued.
REQ-031 redir_valid=1 with redir_pc=0x80000100 during WAIT, response arriving 2 cycles later -> response dropped; next request at 0x80000100; flush pulses one cycle.
REQ-032 trap_valid, mret_valid and redir_valid asserted together (0x80001000 / 0x80002000 / 0x80003000) -> next request at 0x80001000.
REQ-033 Redirect in the same cycle as the request handshake, then the response -> response dropped; next request at the new target.
REQ-034 With YSYX_22050550_FETCH_MISALIGN_EN defined, redir_pc=0x80000102 -> fetch_misalign=1 and imem_req_valid=0 until redir_pc=0x80000200 is accepted.
